// File: rtl/tinker_regfile_sb.sv
// Scoreboarded register file: NREG x DATA_W with per-register pending-write counters.
// Optional macro TINKER_RF_BYPASS_EN forwards same-cycle writeback to read ports.
module tinker_regfile_sb #(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2,
  parameter logic [DATA_W-1:0] SP_RESET = 64'h80000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  flush,
  output logic [DATA_W-1:0]     sp_val,
  output logic [AW:0]           pend_regs,
  output logic                  err
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [DATA_W-1:0] rf_q  [NREG];
  logic [DATA_W-1:0] rf_d  [NREG];
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              err_q;
  logic              err_d;

  logic wr_iss_same;
  logic iss_acc;
  logic wr_cnt_z;
  logic same_acc;

  assign wr_iss_same = wr_en && (wr_addr == iss_addr);
  // A same-cycle writeback frees a slot, so a full counter can still accept.
  assign iss_ready = !((cnt_q[iss_addr] == CMAX) && !wr_iss_same);
  assign iss_acc   = iss_en && iss_ready;
  assign wr_cnt_z  = (cnt_q[wr_addr] == '0);
  assign same_acc  = iss_acc && wr_iss_same;

  always_comb begin
    err_d = err_q;
    if (wr_en && wr_cnt_z && !flush && !same_acc)
      err_d = 1'b1;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);
    logic iss_r;
    logic wr_r;
    logic nz_r;

    assign iss_r = iss_acc && (iss_addr == IDX);
    assign wr_r  = wr_en && (wr_addr == IDX);
    assign nz_r  = (cnt_q[r] != '0);

    always_comb begin
      rf_d[r] = rf_q[r];
      if (wr_r)
        rf_d[r] = wr_data;
    end

    always_comb begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else begin
        unique case (1'b1)
          (iss_r && wr_r):          cnt_d[r] = cnt_q[r];
          (iss_r && !wr_r):         cnt_d[r] = cnt_q[r] + CONE;
          (!iss_r && wr_r && nz_r): cnt_d[r] = cnt_q[r] - CONE;
          default:                  cnt_d[r] = cnt_q[r];
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rf_q[r]  <= (r == NREG-1) ? SP_RESET : '0;
        cnt_q[r] <= '0;
      end else begin
        rf_q[r]  <= rf_d[r];
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  always_comb begin
    pend_regs = '0;
    for (int i = 0; i < NREG; i++)
      pend_regs = pend_regs + {{AW{1'b0}}, (cnt_q[i] != '0)};
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rv;
    logic              bz;

    assign ra = rd_addr[k*AW +: AW];
    assign rv = rf_q[ra];
    assign bz = (cnt_q[ra] != '0);

`ifdef TINKER_RF_BYPASS_EN
    logic byp;
    logic last;

    assign byp  = wr_en && (wr_addr == ra);
    // Busy drops only when this writeback retires the final reservation.
    assign last = byp && (cnt_q[ra] == CONE) &&
                  !(iss_acc && (iss_addr == ra));

    assign rd_data[k*DATA_W +: DATA_W] = byp ? wr_data : rv;
    assign rd_busy[k] = bz && !last;
`else
    assign rd_data[k*DATA_W +: DATA_W] = rv;
    assign rd_busy[k] = bz;
`endif
  end

  assign sp_val = rf_q[NREG-1];
  assign err    = err_q;

endmodule
